// File: rtl/uart_rx.sv
// Serial byte receiver: start / 8 data (LSB first) / stop, sampled mid-bit,
// delivered on a valid/ready port with registered framing and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam bit HALF_ZERO = (HALF == 0);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_BIT   = CW'(CLKS_PER_BIT - 1);
    // START counts down one less than HALF so confirmation lands on the HALF-th edge after entry
    localparam logic [CW-1:0] CNT_START = CW'((HALF > 0) ? (HALF - 1) : 0);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ferr_q, ferr_d;
    logic                   oerr_q, oerr_d;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain next-state: rx enters at stage 0
    always_comb begin
        sync_d[0] = rx;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Receive FSM, shift register and output handshake next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    if (HALF_ZERO) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_START;
                        cnt_d   = CNT_START;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_ZERO) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_BIT;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_ZERO) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CNT_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_ZERO) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        // A pending byte being accepted this edge frees the slot for the new one
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            oerr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{1'b1}};
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign busy        = busy_q;
    assign framing_err = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a default-rate instance and a 16-clocks-per-bit instance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx16;
    logic       rx_ready;
    logic [7:0] rx_data, rx_data16;
    logic       rx_valid, rx_valid16;
    logic       busy, busy16;
    logic       framing_err, framing_err16;
    logic       overrun_err, overrun_err16;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int frame_start = 0;

    int valid_cnt = 0, prev_valid_edge = 0, last_valid_edge = 0;
    int fe_cnt = 0, ov_cnt = 0;
    int v16_cnt = 0, last16_edge = 0, fe16_cnt = 0, ov16_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp16_q[$];

    int v0, fe0, ov0, v16_0, fe16_0, ov16_0;

    uart_rx dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .framing_err(framing_err), .overrun_err(overrun_err)
    );

    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .rx(rx16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready),
        .busy(busy16), .framing_err(framing_err16), .overrun_err(overrun_err16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and one stop bit, each held cpb clocks
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb, input bit use16);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) frame_start = cyc;
                if (use16) rx16 = bits[i];
                else       rx   = bits[i];
            end
        end
    endtask

    // Scoreboard monitor for the default-rate instance
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid && rx_ready) begin
            check("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rx_data", int'(rx_data), int'(e));
            end
            valid_cnt++;
            prev_valid_edge = last_valid_edge;
            last_valid_edge = cyc;
        end
        if (framing_err) fe_cnt++;
        if (overrun_err) ov_cnt++;
    end

    // Scoreboard monitor for the 16-clocks-per-bit instance
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid16 && rx_ready) begin
            check("sb16_nonempty", int'(exp16_q.size() > 0), 1);
            if (exp16_q.size() > 0) begin
                e = exp16_q.pop_front();
                check("rx_data16", int'(rx_data16), int'(e));
            end
            v16_cnt++;
            last16_edge = cyc;
        end
        if (framing_err16) fe16_cnt++;
        if (overrun_err16) ov16_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rx16 = 1'b1; rx_ready = 1'b1;
        idle(3);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_errs", int'({framing_err, overrun_err}), 0);
        check("rst_busy16", int'(busy16), 0);
        @(negedge clk); rst = 1'b0;
        idle(4);

        // 1: single byte, latency 12
        v0 = valid_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        idle(6);
        check("t1_valid_cnt", valid_cnt - v0, 1);
        check("t1_latency", last_valid_edge - frame_start, 12);
        check("t1_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("t1_valid_low", int'(rx_valid), 0);

        // 2: back-to-back with one stop bit
        v0 = valid_cnt;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        send_frame(8'hC3, 1'b1, 1, 1'b0);
        idle(6);
        check("t2_valid_cnt", valid_cnt - v0, 2);
        check("t2_spacing", last_valid_edge - prev_valid_edge, 10);

        // 3: bad stop bit, line held low
        v0 = valid_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1, 1'b0);
        repeat (5) begin @(negedge clk); rx = 1'b0; end
        idle(1);
        check("t3_ferr", fe_cnt - fe0, 1);
        check("t3_busy_low_line", int'(busy), 1);
        @(negedge clk); rx = 1'b1;
        idle(1);
        check("t3_busy_sync", int'(busy), 1);
        idle(6);
        check("t3_busy_idle", int'(busy), 0);
        check("t3_no_valid", valid_cnt - v0, 0);

        // 4: overrun while consumer stalls
        rx_ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        idle(4);
        check("t4_valid_held", int'(rx_valid), 1);
        check("t4_data_kept", int'(rx_data), 32'h11);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_no_ferr", fe_cnt - fe0, 0);
        rx_ready = 1'b1;
        idle(1);
        check("t4_accepted", int'(rx_valid), 0);
        check("t4_sb_drained", exp_q.size(), 0);

        // 5: 16 clocks per bit, glitch then a real frame
        v16_0 = v16_cnt; fe16_0 = fe16_cnt; ov16_0 = ov16_cnt;
        repeat (3) begin @(negedge clk); rx16 = 1'b0; end
        @(negedge clk); rx16 = 1'b1;
        idle(1);
        check("t5_busy_start", int'(busy16), 1);
        idle(20);
        check("t5_glitch_idle", int'(busy16), 0);
        check("t5_glitch_none", (v16_cnt - v16_0) + (fe16_cnt - fe16_0) + (ov16_cnt - ov16_0), 0);
        exp16_q.push_back(8'h80);
        send_frame(8'h80, 1'b1, 16, 1'b1);
        idle(20);
        check("t5_valid_cnt", v16_cnt - v16_0, 1);
        check("t5_latency", last16_edge - frame_start, 154);

        // 6: reset mid-frame after data bit 3
        v0 = valid_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        begin
            logic [4:0] part;
            part = {4'b0110, 1'b0};
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); rx = part[i];
            end
        end
        idle(1);
        check("t6_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(rx_valid), 0);
        check("t6_rst_data", int'(rx_data), 0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(12);
        check("t6_aborted", (valid_cnt - v0) + (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        idle(6);
        check("t6_valid_cnt", valid_cnt - v0, 1);
        check("t6_latency", last_valid_edge - frame_start, 12);
        check("t6_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
